// File: rtl/vending_machine_core.sv
// Parametrised vending controller: edge-detected coin/button intake, per-product
// prices, timed dispense, coin-by-coin change return and BCD credit display.
module vending_machine_core #(
  parameter int                              NUM_PRODUCTS   = 4,
  parameter int                              PRICE_W        = 8,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES         = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int                              MAX_CREDIT     = 95,
  parameter int                              DISPENSE_TICKS = 50,
  parameter int                              TIMEOUT_TICKS  = 1000
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    tick_en,
  input  logic [2:0]              coin_in,
  input  logic [NUM_PRODUCTS-1:0] sel,
  input  logic                    cancel,
  output logic [NUM_PRODUCTS-1:0] dispense,
  output logic                    change_nickel,
  output logic                    change_dime,
  output logic                    coin_reject,
  output logic                    price_short,
  output logic [PRICE_W-1:0]      credit,
  output logic [3:0]              disp_dig1,
  output logic [3:0]              disp_dig2,
  output logic [3:0]              disp_dig3,
  output logic [3:0]              disp_dig4,
  output logic                    busy
);

  localparam int IDX_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
  localparam int TMAX  = (TIMEOUT_TICKS > DISPENSE_TICKS) ? TIMEOUT_TICKS : DISPENSE_TICKS;
  localparam int TIM_W = $clog2(TMAX + 1);
  localparam logic [TIM_W-1:0]   TIMEOUT_T = TIM_W'(TIMEOUT_TICKS);
  localparam logic [TIM_W-1:0]   DISP_T    = TIM_W'(DISPENSE_TICKS);
  localparam logic [PRICE_W:0]   MAX_EXT   = (PRICE_W+1)'(MAX_CREDIT);
  localparam logic [PRICE_W-1:0] C5        = PRICE_W'(5);
  localparam logic [PRICE_W-1:0] C10       = PRICE_W'(10);
  localparam logic [PRICE_W-1:0] C25       = PRICE_W'(25);
  localparam logic [PRICE_W-1:0] C100      = PRICE_W'(100);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_VEND, S_CHANGE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              coin_s_q, coin_s_d, coin_p_q, coin_p_d;
  logic [NUM_PRODUCTS-1:0] sel_s_q, sel_s_d, sel_p_q, sel_p_d;
  logic                    cancel_s_q, cancel_s_d, cancel_p_q, cancel_p_d;
  logic [PRICE_W-1:0]      credit_q, credit_d;
  logic [TIM_W-1:0]        timer_q, timer_d;
  logic [IDX_W-1:0]        vend_idx_q, vend_idx_d;
  logic [NUM_PRODUCTS-1:0] dispense_q, dispense_d;
  logic                    nickel_q, nickel_d, dime_q, dime_d;
  logic                    reject_q, reject_d, short_q, short_d;
  logic [3:0]              dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;
  logic                    busy_q, busy_d;

  logic [PRICE_W-1:0] price_arr [NUM_PRODUCTS];

  for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_price
    assign price_arr[gi] = PRICES[gi*PRICE_W +: PRICE_W];
  end

  logic [2:0]              coin_ev;
  logic [NUM_PRODUCTS-1:0] sel_ev;
  logic                    cancel_ev;
  logic                    coin_one, coin_fit, sel_one, any_ev;
  logic [PRICE_W-1:0]      coin_val, sel_price;
  logic [PRICE_W:0]        coin_sum;
  logic [IDX_W-1:0]        sel_idx;
  logic [TIM_W-1:0]        tim_inc;

  always_comb begin
    coin_ev   = coin_s_q & ~coin_p_q;
    sel_ev    = sel_s_q & ~sel_p_q;
    cancel_ev = cancel_s_q & ~cancel_p_q;
    coin_one  = $onehot(coin_ev);
    sel_one   = $onehot(sel_ev);
    any_ev    = (coin_ev != 3'b000) || (sel_ev != '0) || cancel_ev;
    case (coin_ev)
      3'b001:  coin_val = C5;
      3'b010:  coin_val = C10;
      3'b100:  coin_val = C25;
      default: coin_val = '0;
    endcase
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fit  = (coin_sum <= MAX_EXT);
    tim_inc   = timer_q + TIM_W'(1);
    sel_idx   = '0;
    sel_price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_ev[i]) begin
        sel_idx   = IDX_W'(i);
        sel_price = price_arr[i];
      end
    end
  end

  always_comb begin
    coin_s_d   = coin_in;
    coin_p_d   = coin_s_q;
    sel_s_d    = sel;
    sel_p_d    = sel_s_q;
    cancel_s_d = cancel;
    cancel_p_d = cancel_s_q;
    state_d    = state_q;
    credit_d   = credit_q;
    timer_d    = timer_q;
    vend_idx_d = vend_idx_q;
    dispense_d = dispense_q;
    nickel_d   = 1'b0;
    dime_d     = 1'b0;
    reject_d   = 1'b0;
    short_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_ev != 3'b000) begin
          if (coin_one && coin_fit) begin
            credit_d = coin_sum[PRICE_W-1:0];
            timer_d  = '0;
            state_d  = S_ACCUM;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (any_ev) begin
          timer_d = '0;
        end else if (tick_en) begin
          timer_d = tim_inc;
        end
        // Priority: cancel, then a one-hot select, then coins; a coin that
        // arrives alongside a taken cancel/select is refused.
        if (cancel_ev) begin
          state_d  = S_CHANGE;
          reject_d = (coin_ev != 3'b000);
        end else if (sel_one && (credit_q >= sel_price)) begin
          state_d    = S_VEND;
          credit_d   = credit_q - sel_price;
          dispense_d = sel_ev;
          vend_idx_d = sel_idx;
          reject_d   = (coin_ev != 3'b000);
        end else begin
          short_d = sel_one;
          if (coin_ev != 3'b000) begin
            if (coin_one && coin_fit) begin
              credit_d = coin_sum[PRICE_W-1:0];
            end else begin
              reject_d = 1'b1;
            end
          end else if (!any_ev && tick_en && (tim_inc == TIMEOUT_T)) begin
            state_d = S_CHANGE;
            timer_d = '0;
          end
        end
      end
      S_VEND: begin
        reject_d = (coin_ev != 3'b000);
        if (tick_en) begin
          if (tim_inc == DISP_T) begin
            dispense_d = '0;
            timer_d    = '0;
            state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
          end else begin
            timer_d = tim_inc;
          end
        end
      end
      S_CHANGE: begin
        reject_d = (coin_ev != 3'b000);
        if (tick_en) begin
          if (credit_q >= C10) begin
            dime_d   = 1'b1;
            credit_d = credit_q - C10;
          end else if (credit_q >= C5) begin
            nickel_d = 1'b1;
            credit_d = credit_q - C5;
          end else begin
            credit_d = '0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Digits follow the registered credit, so they trail it by one cycle.
    dig1_d = 4'(credit_q % C10);
    dig2_d = 4'((credit_q / C10) % C10);
    dig3_d = 4'(credit_q / C100);
    dig4_d = (state_d == S_VEND) ? 4'(vend_idx_d) : 4'hF;
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      coin_s_q   <= '0;
      coin_p_q   <= '0;
      sel_s_q    <= '0;
      sel_p_q    <= '0;
      cancel_s_q <= 1'b0;
      cancel_p_q <= 1'b0;
      credit_q   <= '0;
      timer_q    <= '0;
      vend_idx_q <= '0;
      dispense_q <= '0;
      nickel_q   <= 1'b0;
      dime_q     <= 1'b0;
      reject_q   <= 1'b0;
      short_q    <= 1'b0;
      dig1_q     <= 4'h0;
      dig2_q     <= 4'h0;
      dig3_q     <= 4'h0;
      dig4_q     <= 4'hF;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coin_s_q   <= coin_s_d;
      coin_p_q   <= coin_p_d;
      sel_s_q    <= sel_s_d;
      sel_p_q    <= sel_p_d;
      cancel_s_q <= cancel_s_d;
      cancel_p_q <= cancel_p_d;
      credit_q   <= credit_d;
      timer_q    <= timer_d;
      vend_idx_q <= vend_idx_d;
      dispense_q <= dispense_d;
      nickel_q   <= nickel_d;
      dime_q     <= dime_d;
      reject_q   <= reject_d;
      short_q    <= short_d;
      dig1_q     <= dig1_d;
      dig2_q     <= dig2_d;
      dig3_q     <= dig3_d;
      dig4_q     <= dig4_d;
      busy_q     <= busy_d;
    end
  end

  assign dispense      = dispense_q;
  assign change_nickel = nickel_q;
  assign change_dime   = dime_q;
  assign coin_reject   = reject_q;
  assign price_short   = short_q;
  assign credit        = credit_q;
  assign disp_dig1     = dig1_q;
  assign disp_dig2     = dig2_q;
  assign disp_dig3     = dig3_q;
  assign disp_dig4     = dig4_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vending_machine_core.sv
// Directed and randomized bench for vending_machine_core; expectations come from
// a credit/change model built on the pricing and coin rules.
module tb_vending_machine_core;

  localparam int NP   = 4;
  localparam int PW   = 8;
  localparam int DT   = 50;
  localparam int TT   = 1000;
  localparam int MAXC = 95;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          tick_en = 1'b0;
  logic [2:0]    coin_in = 3'b000;
  logic [NP-1:0] sel = '0;
  logic          cancel = 1'b0;
  logic [NP-1:0] dispense;
  logic          change_nickel, change_dime, coin_reject, price_short, busy;
  logic [PW-1:0] credit;
  logic [3:0]    disp_dig1, disp_dig2, disp_dig3, disp_dig4;

  vending_machine_core #(
    .NUM_PRODUCTS  (NP),
    .PRICE_W       (PW),
    .PRICES        ({8'd30, 8'd25, 8'd20, 8'd15}),
    .MAX_CREDIT    (MAXC),
    .DISPENSE_TICKS(DT),
    .TIMEOUT_TICKS (TT)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .tick_en      (tick_en),
    .coin_in      (coin_in),
    .sel          (sel),
    .cancel       (cancel),
    .dispense     (dispense),
    .change_nickel(change_nickel),
    .change_dime  (change_dime),
    .coin_reject  (coin_reject),
    .price_short  (price_short),
    .credit       (credit),
    .disp_dig1    (disp_dig1),
    .disp_dig2    (disp_dig2),
    .disp_dig3    (disp_dig3),
    .disp_dig4    (disp_dig4),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Tick strobe on every other cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1 tick_en = ~tick_en;
    end
  end

  int checks = 0;
  int failures = 0;
  int mcredit = 0;

  int dime_cnt = 0, nickel_cnt = 0, rej_cnt = 0, short_cnt = 0;
  int vend_cnt = 0, disp_ticks = 0, width_err = 0;
  logic [NP-1:0] disp_last = '0;
  logic [3:0]    dig4_vend = 4'h0;
  logic pd = 1'b0, pn = 1'b0, pr = 1'b0, ps = 1'b0;
  logic [NP-1:0] pdisp = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (change_dime)   dime_cnt++;
      if (change_nickel) nickel_cnt++;
      if (coin_reject)   rej_cnt++;
      if (price_short)   short_cnt++;
      if ((change_dime && pd) || (change_nickel && pn) || (coin_reject && pr) || (price_short && ps))
        width_err++;
      if (dispense != '0 && pdisp == '0) vend_cnt++;
      if (dispense != '0) begin
        disp_last = dispense;
        dig4_vend = disp_dig4;
        if (tick_en) disp_ticks++;
      end
      pd = change_dime; pn = change_nickel; pr = coin_reject; ps = price_short;
      pdisp = dispense;
    end
  end

  function automatic int price_of(input int i);
    case (i)
      0: return 15;
      1: return 20;
      2: return 25;
      default: return 30;
    endcase
  endfunction

  function automatic int coin_value(input logic [2:0] b);
    case (b)
      3'b001: return 5;
      3'b010: return 10;
      3'b100: return 25;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_coin(input logic [2:0] bits);
    coin_in = bits;
    cyc(2);
    coin_in = 3'b000;
    cyc(3);
  endtask

  task automatic check_display();
    check("dig1", disp_dig1, mcredit % 10);
    check("dig2", disp_dig2, (mcredit / 10) % 10);
    check("dig3", disp_dig3, mcredit / 100);
    check("dig4_idle", disp_dig4, 4'hF);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || dispense !== '0) && n < 3000) begin
      cyc(1);
      n++;
    end
    check("idle_wait_bound", n < 3000, 1);
  endtask

  task automatic do_coin(input logic [2:0] bits);
    int r0 = rej_cnt;
    int exp_rej;
    int v = coin_value(bits);
    if ($countones(bits) == 1 && mcredit + v <= MAXC) begin
      mcredit += v;
      exp_rej = 0;
    end else begin
      exp_rej = 1;
    end
    drive_coin(bits);
    cyc(1);
    check("coin_credit", credit, mcredit);
    check("coin_reject", rej_cnt - r0, exp_rej);
    check_display();
    $display("txn coin bits=%b credit=%0d reject=%0d", bits, credit, rej_cnt - r0);
  endtask

  task automatic do_sel(input int idx, input int hold, input bit poke);
    int s_d = dime_cnt, s_n = nickel_cnt, s_v = vend_cnt, s_t = disp_ticks;
    int s_s = short_cnt, s_r = rej_cnt;
    int price = price_of(idx);
    bit vend = (mcredit >= price);
    int rem = mcredit - price;
    sel = NP'(1) << idx;
    cyc(hold);
    sel = '0;
    if (poke) begin
      drive_coin(3'b001);
      check("busy_coin_reject", rej_cnt - s_r, 1);
    end
    cyc(1);
    wait_idle();
    cyc(2);
    if (vend) begin
      check("vend_count", vend_cnt - s_v, 1);
      check("vend_onehot", disp_last, NP'(1) << idx);
      check("vend_ticks", disp_ticks - s_t, DT);
      check("vend_dig4", dig4_vend, idx);
      check("vend_dimes", dime_cnt - s_d, rem / 10);
      check("vend_nickels", nickel_cnt - s_n, (rem % 10) / 5);
      check("vend_short", short_cnt - s_s, 0);
      mcredit = 0;
    end else begin
      check("short_pulse", short_cnt - s_s, 1);
      check("short_no_vend", vend_cnt - s_v, 0);
      check("short_busy", busy, 0);
    end
    check("sel_credit", credit, mcredit);
    check_display();
    $display("txn sel idx=%0d vend=%0d credit=%0d dimes=%0d nickels=%0d",
             idx, vend, credit, dime_cnt - s_d, nickel_cnt - s_n);
  endtask

  task automatic do_cancel();
    int s_d = dime_cnt, s_n = nickel_cnt;
    int rem = mcredit;
    cancel = 1'b1;
    cyc(3);
    cancel = 1'b0;
    wait_idle();
    cyc(2);
    check("cancel_dimes", dime_cnt - s_d, rem / 10);
    check("cancel_nickels", nickel_cnt - s_n, (rem % 10) / 5);
    check("cancel_credit", credit, 0);
    mcredit = 0;
    $display("txn cancel refund=%0d dimes=%0d nickels=%0d", rem, dime_cnt - s_d, nickel_cnt - s_n);
  endtask

  initial begin
    int n;
    int s_d, s_n;
    cyc(4);
    check("rst_credit", credit, 0);
    check("rst_dispense", dispense, 0);
    check("rst_busy", busy, 0);
    check("rst_dig4", disp_dig4, 4'hF);
    check("rst_dig1", disp_dig1, 0);
    clr = 1'b0;
    cyc(2);
    $display("txn reset released");

    // 25c + 10c, buy product 0, a coin during the vend is refused.
    do_coin(3'b100);
    do_coin(3'b010);
    do_sel(0, 3, 1'b1);

    // Credit ceiling.
    do_coin(3'b100); do_coin(3'b100); do_coin(3'b100); do_coin(3'b010);
    do_coin(3'b100);
    do_coin(3'b010);
    do_coin(3'b001);
    do_cancel();

    // Insufficient credit, then exact payment.
    do_coin(3'b010); do_coin(3'b010);
    do_sel(3, 3, 1'b0);
    do_coin(3'b010);
    do_sel(3, 3, 1'b0);

    // Simultaneous coins, then a long-held select.
    do_coin(3'b100);
    do_coin(3'b011);
    do_sel(1, 100, 1'b0);

    // Inactivity timeout at 15c, then cancel at 5c.
    do_coin(3'b010); do_coin(3'b001);
    s_d = dime_cnt; s_n = nickel_cnt;
    n = 0;
    while (busy !== 1'b1 && n < 2600) begin cyc(1); n++; end
    check("timeout_bound", n < 2600, 1);
    check("timeout_latency", (n >= 1980) && (n <= 2010), 1);
    wait_idle();
    cyc(2);
    check("timeout_dimes", dime_cnt - s_d, 1);
    check("timeout_nickels", nickel_cnt - s_n, 1);
    check("timeout_credit", credit, 0);
    mcredit = 0;
    $display("txn timeout refund waited=%0d cycles", n);
    do_coin(3'b001);
    do_cancel();

    // Reset during change payout.
    do_coin(3'b100); do_coin(3'b010); do_coin(3'b001);
    s_d = dime_cnt;
    cancel = 1'b1;
    cyc(3);
    cancel = 1'b0;
    n = 0;
    while (dime_cnt == s_d && n < 200) begin cyc(1); n++; end
    check("clr_dime_seen", n < 200, 1);
    clr = 1'b1;
    #1;
    check("clr_credit", credit, 0);
    check("clr_busy", busy, 0);
    check("clr_dispense", dispense, 0);
    check("clr_dig4", disp_dig4, 4'hF);
    s_d = dime_cnt; s_n = nickel_cnt;
    cyc(2);
    clr = 1'b0;
    cyc(100);
    check("clr_no_dimes", dime_cnt - s_d, 0);
    check("clr_no_nickels", nickel_cnt - s_n, 0);
    check("clr_credit_after", credit, 0);
    mcredit = 0;
    $display("txn clr during change");

    // Randomized traffic against the model.
    for (int it = 0; it < 24; it++) begin
      int act = $urandom_range(0, 9);
      if (act <= 5 || mcredit == 0) begin
        logic [2:0] b;
        if ($urandom_range(0, 5) == 0) begin
          b = 3'($urandom_range(0, 3));
          b = (b == 3'd0) ? 3'b011 : (b == 3'd1) ? 3'b101 : (b == 3'd2) ? 3'b110 : 3'b111;
        end else begin
          b = 3'b001 << $urandom_range(0, 2);
        end
        do_coin(b);
      end else if (act <= 8) begin
        do_sel($urandom_range(0, NP - 1), $urandom_range(3, 6), 1'b0);
      end else begin
        do_cancel();
      end
    end
    if (mcredit != 0) do_cancel();

    check("pulse_width", width_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vending_machine_core.md
Name: vending_machine_core

Overview:
- Parametrised successor to the fixed four-product vending controller.
- Handles N products with per-product prices, edge-detected coin intake (5c/10c/25c), credit overflow rejection, cancel/timeout refund, and coin-by-coin change return.
- Emits dispense LEDs and four display digits in the format the existing seven-segment Display block takes.
- Runs on the system clock; slow timing (dispense hold, change pacing, timeout) is gated by tick_en from the existing Clock_Enable divider.

Parameters:
- NUM_PRODUCTS, 4, number of products (1..8).
- PRICE_W, 8, credit/price width in bits.
- PRICES, {8'd30,8'd25,8'd20,8'd15}, packed prices, NUM_PRODUCTS*PRICE_W bits; product 0 in the LSBs. Every price is a nonzero multiple of 5 and no greater than MAX_CREDIT.
- MAX_CREDIT, 95, highest credit accepted.
- DISPENSE_TICKS, 50, tick_en pulses the dispense LED is held.
- TIMEOUT_TICKS, 1000, idle tick_en pulses in ACCUM before auto-refund.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- tick_en  in  1  one-cycle clock-enable strobe.
- coin_in  in  3  level coin sensors: bit0 = 5c, bit1 = 10c, bit2 = 25c.
- sel  in  NUM_PRODUCTS  product buttons, level.
- cancel  in  1  refund button, level.
- dispense  out  NUM_PRODUCTS  one-hot dispense LEDs; LSB = product 0.
- change_nickel  out  1  one-cycle 5c payout pulse.
- change_dime  out  1  one-cycle 10c payout pulse.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- price_short  out  1  one-cycle pulse when a selection has insufficient credit.
- credit  out  PRICE_W  current credit in cents.
- disp_dig1..disp_dig4  out  4 each  display nibbles; dig1 = ones.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (clr high, asynchronous):
  - State goes to IDLE.
  - credit, dispense, all pulse outputs, timers and edge-detect registers go to 0.
  - disp_dig1..3 = 0; disp_dig4 = 4'hF (blank).
  - Reset mid-VEND or mid-CHANGE discards the remaining credit; no payout follows.
- Edge detection:
  - coin_in, sel and cancel are registered once; an event is the rising edge (prev 0, now 1).
  - Holding a button produces exactly one event.
- States:
  - IDLE: credit = 0. A valid coin moves to ACCUM.
  - ACCUM:
    - Coin event: accepted if exactly one coin bit rises and credit + value <= MAX_CREDIT. Credit updates on the next edge.
    - A coin that would exceed MAX_CREDIT gets coin_reject = 1 and credit is unchanged.
    - More than one coin bit rising in the same cycle: coin_reject = 1, all coins refused, credit unchanged.
    - Select event: exactly one sel bit must rise, else the event is ignored.
      - credit >= PRICES[i]: go to VEND, credit -= PRICES[i], dispense[i] = 1.
      - Otherwise: price_short = 1 and stay in ACCUM.
    - Cancel event: go to CHANGE.
    - Cancel and select in the same cycle: cancel wins.
    - Timeout: a counter increments on each tick_en and clears on any coin, select or cancel event. Reaching TIMEOUT_TICKS goes to CHANGE.
  - VEND:
    - Holds dispense[i] for DISPENSE_TICKS tick_en pulses, then clears dispense.
    - Then goes to CHANGE if credit > 0, else IDLE.
  - CHANGE:
    - On each tick_en: if credit >= 10, pulse change_dime and credit -= 10; else if credit >= 5, pulse change_nickel and credit -= 5.
    - When credit == 0, go to IDLE; no pulse is emitted on that tick.
  - In VEND and CHANGE, coin events get coin_reject; sel and cancel are ignored.
- Display:
  - dig3/dig2/dig1 = BCD hundreds/tens/ones of credit, registered with 1-cycle latency after credit changes.
  - dig4 = selected product index (0..NUM_PRODUCTS-1) during VEND; 4'hF otherwise.
- Arithmetic:
  - Credit add and subtract are unsigned PRICE_W-bit.
  - Overflow is impossible given the MAX_CREDIT check; underflow is impossible given the >= checks.
- Pulses: every pulse output is exactly one clk cycle wide.

Test Plan:
- Reset, then a 25c edge then a 10c edge -> credit 35; digits 5,3,0,F. Select sel[0] (15c) -> dispense = 4'b0001 for 50 ticks and dig4 = 0. Then CHANGE pays exactly two change_dime pulses on successive ticks, then IDLE with credit 0.
- Credit 85, insert 25c -> coin_reject pulse; credit stays 85. Insert 10c -> credit 95. Insert 5c -> coin_reject pulse.
- Credit 20, select sel[3] (30c) -> price_short pulse; no dispense; state ACCUM. Add 10c and select again -> vend with 0 change; straight to IDLE after the hold.
- 5c and 10c rising in the same cycle -> coin_reject; credit unchanged. Sel held high for 100 cycles -> a single vend.
- Credit 15 with no activity for 1000 ticks -> CHANGE: change_dime then change_nickel, then IDLE. Cancel at credit 5 -> one change_nickel.
- Assert clr during CHANGE with credit 40 -> immediate IDLE; credit 0; no further payout pulses; dispense 0.
